// File: rtl/vga_timing_pkg.sv
// 640x480@60 timing constants, coordinate type and renderer colours.
// Shared by vga_sync_gen and every object renderer.
package vga_timing_pkg;

    localparam int unsigned COORD_W = 10;

    localparam int unsigned VGA_CLK_DIV   = 4;
    localparam int unsigned VGA_H_DISPLAY = 640;
    localparam int unsigned VGA_H_FRONT   = 16;
    localparam int unsigned VGA_H_SYNC    = 96;
    localparam int unsigned VGA_H_BACK    = 48;
    localparam int unsigned VGA_V_DISPLAY = 480;
    localparam int unsigned VGA_V_FRONT   = 10;
    localparam int unsigned VGA_V_SYNC    = 2;
    localparam int unsigned VGA_V_BACK    = 33;

    localparam int unsigned VGA_H_TOTAL =
        VGA_H_DISPLAY + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
    localparam int unsigned VGA_V_TOTAL =
        VGA_V_DISPLAY + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [11:0]        rgb_t;

    localparam rgb_t BLACK = 12'h000;
    localparam rgb_t WHITE = 12'hFFF;
    localparam rgb_t GRAY  = 12'h888;
    localparam rgb_t RED   = 12'hF00;

    function automatic logic in_span(
        input coord_t v,
        input coord_t lo,
        input coord_t hi
    );
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/vga_sync_gen_pixel_tick_gen.sv
// Clock divider: p_tick is a registered one-clk pulse on the last
// clk of every CLK_DIV-clk period (div_cnt == CLK_DIV-1).
module pixel_tick_gen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic p_tick
);

    localparam int unsigned DW = $clog2(CLK_DIV);
    localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] PRE  = DW'(CLK_DIV - 2);

    logic [DW-1:0] div_cnt;

    // p_tick is registered one step ahead so it lines up with div_cnt==LAST
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            p_tick  <= 1'b0;
        end else begin
            div_cnt <= (div_cnt >= LAST) ? '0 : div_cnt + DW'(1);
            p_tick  <= (div_cnt == PRE);
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA 640x480@60 sync generator; all outputs registered and aligned.
// Define VGA_FRAME_COUNT_EN to add the 8-bit frame_cnt output.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned CLK_DIV   = VGA_CLK_DIV,
    parameter int unsigned H_DISPLAY = VGA_H_DISPLAY,
    parameter int unsigned H_FRONT   = VGA_H_FRONT,
    parameter int unsigned H_SYNC    = VGA_H_SYNC,
    parameter int unsigned H_BACK    = VGA_H_BACK,
    parameter int unsigned V_DISPLAY = VGA_V_DISPLAY,
    parameter int unsigned V_FRONT   = VGA_V_FRONT,
    parameter int unsigned V_SYNC    = VGA_V_SYNC,
    parameter int unsigned V_BACK    = VGA_V_BACK
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               p_tick,
    output logic [COORD_W-1:0] pixel_x,
    output logic [COORD_W-1:0] pixel_y,
    output logic               video_on,
    output logic               hsync,
    output logic               vsync,
`ifdef VGA_FRAME_COUNT_EN
    output logic [7:0]         frame_cnt,
`endif
    output logic               frame_start
);

    localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam coord_t H_LAST = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST = coord_t'(V_TOTAL - 1);
    localparam coord_t H_VIS  = coord_t'(H_DISPLAY);
    localparam coord_t V_VIS  = coord_t'(V_DISPLAY);
    localparam coord_t HS_LO  = coord_t'(H_DISPLAY + H_FRONT);
    localparam coord_t HS_HI  = coord_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam coord_t VS_LO  = coord_t'(V_DISPLAY + V_FRONT);
    localparam coord_t VS_HI  = coord_t'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    coord_t x_next;
    coord_t y_next;
    logic   line_end;
    logic   frame_wrap;

    pixel_tick_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .p_tick(p_tick)
    );

    // Out-of-range counts take the wrap branch, so no illegal state persists
    always_comb begin
        x_next     = pixel_x;
        y_next     = pixel_y;
        line_end   = 1'b0;
        frame_wrap = 1'b0;
        if (p_tick) begin
            if (pixel_x >= H_LAST) begin
                x_next   = '0;
                line_end = 1'b1;
            end else begin
                x_next = pixel_x + coord_t'(1);
            end
            if (line_end) begin
                if (pixel_y >= V_LAST) begin
                    y_next     = '0;
                    frame_wrap = 1'b1;
                end else begin
                    y_next = pixel_y + coord_t'(1);
                end
            end
        end
    end

    // Decode from next-state values so sync/video align with coordinates
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_x     <= '0;
            pixel_y     <= '0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            video_on    <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            pixel_x     <= x_next;
            pixel_y     <= y_next;
            hsync       <= ~in_span(x_next, HS_LO, HS_HI);
            vsync       <= ~in_span(y_next, VS_LO, VS_HI);
            video_on    <= (x_next < H_VIS) && (y_next < V_VIS);
            frame_start <= frame_wrap;
        end
    end

`ifdef VGA_FRAME_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
        end else if (frame_wrap) begin
            frame_cnt <= frame_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: full-size instance for line timing and async reset,
// shrunken instance (8x7 pixels, CLK_DIV=2) for frame-level timing.
module tb_vga_sync_gen;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       p_tick, hsync, vsync, video_on, frame_start;
    logic [9:0] pixel_x, pixel_y;
    logic       s_p_tick, s_hsync, s_vsync, s_video_on, s_frame_start;
    logic [9:0] s_x, s_y;
`ifdef VGA_FRAME_COUNT_EN
    logic [7:0] frame_cnt, s_frame_cnt;
`endif

    int errors = 0;
    int checks = 0;
    int n = 0;

    always #5 clk = ~clk;

    vga_sync_gen dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .p_tick     (p_tick),
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y),
        .video_on   (video_on),
        .hsync      (hsync),
        .vsync      (vsync),
`ifdef VGA_FRAME_COUNT_EN
        .frame_cnt  (frame_cnt),
`endif
        .frame_start(frame_start)
    );

    vga_sync_gen #(
        .CLK_DIV(2),
        .H_DISPLAY(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_DISPLAY(3), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
    ) dut_s (
        .clk        (clk),
        .rst_n      (rst_n),
        .p_tick     (s_p_tick),
        .pixel_x    (s_x),
        .pixel_y    (s_y),
        .video_on   (s_video_on),
        .hsync      (s_hsync),
        .vsync      (s_vsync),
`ifdef VGA_FRAME_COUNT_EN
        .frame_cnt  (s_frame_cnt),
`endif
        .frame_start(s_frame_start)
    );

    task automatic step();
        @(posedge clk);
        #1;
        n++;
    endtask

    task automatic test_reset();
        int first;
        rst_n = 1'b0;
        repeat (3) step();
        checks++;
        if ({pixel_x, pixel_y} !== 20'd0) begin
            errors++;
            $display("FAIL rst_xy: got x=%0d y=%0d expected 0 0", pixel_x, pixel_y);
        end
        checks++;
        if ({p_tick, hsync, vsync, video_on, frame_start} !== 5'b01100) begin
            errors++;
            $display("FAIL rst_flags: got %b expected 01100",
                     {p_tick, hsync, vsync, video_on, frame_start});
        end
        checks++;
        if ({s_p_tick, s_hsync, s_vsync, s_video_on, s_frame_start, s_x, s_y}
            !== {5'b01100, 20'd0}) begin
            errors++;
            $display("FAIL rst_small: got flags=%b x=%0d y=%0d expected 01100 0 0",
                     {s_p_tick, s_hsync, s_vsync, s_video_on, s_frame_start}, s_x, s_y);
        end
`ifdef VGA_FRAME_COUNT_EN
        checks++;
        if (frame_cnt !== 8'd0) begin
            errors++;
            $display("FAIL rst_frame_cnt: got %0d expected 0", frame_cnt);
        end
`endif
        #4 rst_n = 1'b1;
        n = 0;
        step();
        checks++;
        if (video_on !== 1'b1 || p_tick !== 1'b0) begin
            errors++;
            $display("FAIL edge1: got video_on=%b p_tick=%b expected 1 0", video_on, p_tick);
        end
        first = -1;
        for (int i = 0; i < 10 && first < 0; i++) begin
            if (p_tick === 1'b1) first = n;
            else step();
        end
        checks++;
        if (first != 3) begin
            errors++;
            $display("FAIL first_tick: got edge %0d expected 3 (4th clk)", first);
        end
        checks++;
        if (pixel_x !== 10'd0 || pixel_y !== 10'd0 || hsync !== 1'b1 || vsync !== 1'b1) begin
            errors++;
            $display("FAIL tick_state: got x=%0d y=%0d hs=%b vs=%b expected 0 0 1 1",
                     pixel_x, pixel_y, hsync, vsync);
        end
    endtask

    task automatic test_line();
        int hs_fall = -1, hs_x = -1, hs_low = 0;
        int vo_fall = -1, vo_x = -1;
        int y1 = -1, y1_x = -1, y2 = -1;
        int maxx = 0, ticks = 0, unstable = 0, fs_seen = 0, vs_low = 0;
        logic y1_vo = 1'b0;
        int prev_x = int'(pixel_x);
        while (n < 6400) begin
            step();
            if (p_tick && n <= 3203) ticks++;
            if (int'(pixel_x) != prev_x && (n % 4) != 0) unstable++;
            prev_x = int'(pixel_x);
            if (!hsync && hs_fall < 0) begin
                hs_fall = n;
                hs_x = int'(pixel_x);
            end
            if (!hsync && n <= 3200) hs_low++;
            if (!video_on && vo_fall < 0) begin
                vo_fall = n;
                vo_x = int'(pixel_x);
            end
            if (pixel_y == 10'd1 && y1 < 0) begin
                y1 = n;
                y1_x = int'(pixel_x);
                y1_vo = video_on;
            end
            if (pixel_y == 10'd2 && y2 < 0) y2 = n;
            if (int'(pixel_x) > maxx) maxx = int'(pixel_x);
            if (frame_start) fs_seen++;
            if (!vsync) vs_low++;
        end
        checks++;
        if (hs_fall != 2624 || hs_x != 656) begin
            errors++;
            $display("FAIL hsync_start: got edge %0d x=%0d expected 2624 656", hs_fall, hs_x);
        end
        checks++;
        if (hs_low != 384) begin
            errors++;
            $display("FAIL hsync_width: got %0d expected 384", hs_low);
        end
        checks++;
        if (vo_fall != 2560 || vo_x != 640) begin
            errors++;
            $display("FAIL video_off: got edge %0d x=%0d expected 2560 640", vo_fall, vo_x);
        end
        checks++;
        if (maxx != 799) begin
            errors++;
            $display("FAIL max_x: got %0d expected 799", maxx);
        end
        checks++;
        if (y1 != 3200 || y1_x != 0 || y1_vo !== 1'b1) begin
            errors++;
            $display("FAIL line_wrap: got edge %0d x=%0d vo=%b expected 3200 0 1",
                     y1, y1_x, y1_vo);
        end
        checks++;
        if (y2 - y1 != 3200) begin
            errors++;
            $display("FAIL line_len: got %0d expected 3200", y2 - y1);
        end
        checks++;
        if (ticks != 800) begin
            errors++;
            $display("FAIL tick_count: got %0d expected 800", ticks);
        end
        checks++;
        if (unstable != 0) begin
            errors++;
            $display("FAIL x_hold: got %0d off-phase changes expected 0", unstable);
        end
        checks++;
        if (fs_seen != 0 || vs_low != 0) begin
            errors++;
            $display("FAIL no_frame: got fs=%0d vs_low=%0d expected 0 0", fs_seen, vs_low);
        end
    endtask

    task automatic test_async_reset();
        while (n < 7600) step();
        checks++;
        if (pixel_x !== 10'd300 || pixel_y !== 10'd2 || video_on !== 1'b1) begin
            errors++;
            $display("FAIL pre_abort: got x=%0d y=%0d vo=%b expected 300 2 1",
                     pixel_x, pixel_y, video_on);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({pixel_x, pixel_y} !== 20'd0
            || {p_tick, hsync, vsync, video_on, frame_start} !== 5'b01100) begin
            errors++;
            $display("FAIL async_abort: got x=%0d y=%0d flags=%b expected 0 0 01100",
                     pixel_x, pixel_y, {p_tick, hsync, vsync, video_on, frame_start});
        end
        step();
        #3 rst_n = 1'b1;
        n = 0;
        repeat (4) step();
        checks++;
        if (pixel_x !== 10'd1 || pixel_y !== 10'd0 || video_on !== 1'b1) begin
            errors++;
            $display("FAIL restart: got x=%0d y=%0d vo=%b expected 1 0 1",
                     pixel_x, pixel_y, video_on);
        end
    endtask

    task automatic test_frame();
        int fs_first = -1, fs_cnt = 0, fs_bad = 0;
        int vs_fall = -1, vs_low = 0, vo_high = 0, vo_late = 0, hs_low = 0;
        int maxx = 0, maxy = 0;
`ifdef VGA_FRAME_COUNT_EN
        int fc_bad = 0, fc_255 = -1;
`endif
        rst_n = 1'b0;
        step();
        #4 rst_n = 1'b1;
        n = 0;
        while (n < 257 * 112) begin
            step();
            if (s_frame_start) begin
                fs_cnt++;
                if (fs_first < 0) fs_first = n;
                if (n % 112 != 0) fs_bad++;
            end
            if (!s_vsync && vs_fall < 0) vs_fall = n;
            if (!s_vsync && n <= 112) vs_low++;
            if (s_video_on && n <= 112) vo_high++;
            if (s_video_on && s_y >= 10'd3) vo_late++;
            if (!s_hsync && n <= 16) hs_low++;
            if (int'(s_x) > maxx) maxx = int'(s_x);
            if (int'(s_y) > maxy) maxy = int'(s_y);
`ifdef VGA_FRAME_COUNT_EN
            if (int'(s_frame_cnt) != fs_cnt % 256) fc_bad++;
            if (n == 255 * 112) fc_255 = int'(s_frame_cnt);
`endif
        end
        checks++;
        if (fs_first != 112) begin
            errors++;
            $display("FAIL frame_first: got edge %0d expected 112", fs_first);
        end
        checks++;
        if (fs_cnt != 257 || fs_bad != 0) begin
            errors++;
            $display("FAIL frame_pulses: got %0d (off-period %0d) expected 257 (0)",
                     fs_cnt, fs_bad);
        end
        checks++;
        if (vs_fall != 64 || vs_low != 32) begin
            errors++;
            $display("FAIL vsync: got start %0d width %0d expected 64 32", vs_fall, vs_low);
        end
        checks++;
        if (vo_high != 24 || vo_late != 0) begin
            errors++;
            $display("FAIL video_frame: got on=%0d late=%0d expected 24 0", vo_high, vo_late);
        end
        checks++;
        if (hs_low != 4) begin
            errors++;
            $display("FAIL small_hsync: got %0d expected 4", hs_low);
        end
        checks++;
        if (maxx != 7 || maxy != 6) begin
            errors++;
            $display("FAIL small_range: got x=%0d y=%0d expected 7 6", maxx, maxy);
        end
`ifdef VGA_FRAME_COUNT_EN
        checks++;
        if (fc_bad != 0) begin
            errors++;
            $display("FAIL frame_cnt_track: got %0d mismatching clks expected 0", fc_bad);
        end
        checks++;
        if (fc_255 != 255 || s_frame_cnt !== 8'd1) begin
            errors++;
            $display("FAIL frame_cnt_wrap: got %0d then %0d expected 255 then 1",
                     fc_255, s_frame_cnt);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_line();
        test_async_reset();
        test_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
